// File: rtl/frame_retriever_pkg.sv
// frame_retriever_pkg
//   Shared definitions for the frame retriever: FSM state encoding,
//   parameter default values and the width of the read-latency counter.
package frame_retriever_pkg;

  localparam int unsigned ADDR_W_DEF      = 16;
  localparam int unsigned BPW_DEF         = 1;
  localparam int unsigned RD_LAT_DEF      = 1;
  localparam int unsigned DRAIN_TICKS_DEF = 2;

  // RD_LAT is limited to 1..3, so two bits cover the latency counter.
  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer
//   Holds one memory word and hands it to the UART transmitter one byte at
//   a time, lowest lane first, using a valid/ready handshake.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   clr          drop the current word immediately (abort)
//   load         capture word and start presenting lane 0
//   word         8*BPW-bit memory word
//   tx_ready     transmitter accepts tx_data this cycle
//   tx_data      byte presented to the transmitter (registered)
//   tx_valid     tx_data valid (registered)
//   word_done    last lane accepted this cycle (combinational)
module byte_serializer #(
  parameter int unsigned BPW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [8*BPW-1:0] word,
  input  logic             tx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             word_done
);

  localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);
  localparam logic [LANE_W-1:0] ONE_LANE  = LANE_W'(1'b1);

  logic [8*BPW-1:0]  word_q, word_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;

  // Select byte lane k of a word.
  function automatic logic [7:0] lane_byte(input logic [8*BPW-1:0] w,
                                           input logic [LANE_W-1:0] k);
    logic [7:0] b;
    b = w[7:0];
    for (int i = 0; i < int'(BPW); i++) begin
      if (k == LANE_W'(i)) begin
        b = w[8*i +: 8];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Lane sequencing: tx_data is updated to the next lane in the very cycle
  // the current one is accepted, so it never changes while stalled.
  always_comb begin
    word_d     = word_q;
    lane_d     = lane_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    word_done  = 1'b0;
    if (clr) begin
      tx_valid_d = 1'b0;
      lane_d     = '0;
    end else if (load) begin
      word_d     = word;
      lane_d     = '0;
      tx_data_d  = word[7:0];
      tx_valid_d = 1'b1;
    end else if (tx_valid_q && tx_ready) begin
      if (lane_q == LAST_LANE) begin
        tx_valid_d = 1'b0;
        lane_d     = '0;
        word_done  = 1'b1;
      end else begin
        lane_d    = lane_q + ONE_LANE;
        tx_data_d = lane_byte(word_q, lane_q + ONE_LANE);
      end
    end else begin
      tx_valid_d = tx_valid_q;
    end
  end

  // Serializer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q     <= '0;
      lane_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      word_q     <= word_d;
      lane_q     <= lane_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/frame_retriever.sv
// frame_retriever
//   Reads a block of words from a synchronous memory and streams it byte
//   by byte to a UART transmitter, then waits for the transmitter to drain.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start_n              active-low start request (falling edge starts)
//   abort                cancel current frame
//   base_addr, last_idx  first word address and word count minus 1
//   mem_addr, mem_ren    memory read request
//   mem_rdata            read data, valid RD_LAT cycles after mem_ren
//   tx_data, tx_valid    byte stream to the transmitter
//   tx_ready, tx_tick    transmitter accept and byte-complete pulse
//   busy, fin, aborted   status: frame active, normal end, abort end
module frame_retriever
  import frame_retriever_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned BPW         = BPW_DEF,
  parameter int unsigned RD_LAT      = RD_LAT_DEF,
  parameter int unsigned DRAIN_TICKS = DRAIN_TICKS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_n,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  input  logic [8*BPW-1:0]  mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              tx_tick,
  output logic              busy,
  output logic              fin,
  output logic              aborted
);

  localparam int unsigned TICK_W = $clog2(DRAIN_TICKS + 1) + 1;
  localparam logic [TICK_W-1:0] TICK_TARGET = TICK_W'(DRAIN_TICKS);
  localparam logic [TICK_W-1:0] ONE_TICK    = TICK_W'(1'b1);
  localparam logic [LAT_W-1:0]  LAT_LAST    = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0]  ONE_LAT     = LAT_W'(1'b1);
  localparam logic [ADDR_W-1:0] ONE_ADDR    = ADDR_W'(1'b1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ren_q, mem_ren_d;
  logic              busy_q, busy_d;
  logic              fin_q, fin_d;
  logic              aborted_q, aborted_d;
  // Remembers that start was already requested last cycle; resets to 1 so a
  // start_n held low through reset release is not taken as a new request.
  logic              start_seen_q, start_seen_d;

  logic              start_edge_s;
  logic              ser_load_s;
  logic              ser_clr_s;
  logic              word_done_s;

  byte_serializer #(
    .BPW(BPW)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ser_clr_s),
    .load     (ser_load_s),
    .word     (mem_rdata),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .word_done(word_done_s)
  );

  assign start_edge_s = !start_seen_q && !start_n;

  // Next-state and output logic; abort overrides every other event.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    last_d       = last_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    tick_d       = tick_q;
    mem_addr_d   = mem_addr_q;
    mem_ren_d    = 1'b0;
    aborted_d    = 1'b0;
    ser_load_s   = 1'b0;
    ser_clr_s    = 1'b0;
    start_seen_d = !start_n;
    if ((state_q != ST_IDLE) && abort) begin
      state_d   = ST_IDLE;
      ser_clr_s = 1'b1;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            base_d     = base_addr;
            last_d     = last_idx;
            idx_d      = '0;
            lat_d      = '0;
            tick_d     = '0;
            mem_addr_d = base_addr;
            mem_ren_d  = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: begin
          // lat_q counts cycles since mem_ren; data is on the bus at RD_LAT.
          if (lat_q == LAT_LAST) begin
            ser_load_s = 1'b1;
            state_d    = ST_SEND;
          end else begin
            lat_d = lat_q + ONE_LAT;
          end
        end
        ST_SEND: begin
          if (word_done_s) begin
            if (idx_q == last_q) begin
              // A tick in the same cycle as the last accept already counts.
              if (tx_tick) begin
                if (ONE_TICK >= TICK_TARGET) begin
                  state_d = ST_DONE;
                end else begin
                  tick_d  = ONE_TICK;
                  state_d = ST_DRAIN;
                end
              end else begin
                tick_d  = '0;
                state_d = ST_DRAIN;
              end
            end else begin
              idx_d      = idx_q + ONE_ADDR;
              mem_addr_d = base_q + idx_q + ONE_ADDR;
              mem_ren_d  = 1'b1;
              lat_d      = '0;
              state_d    = ST_FETCH;
            end
          end else begin
            state_d = ST_SEND;
          end
        end
        ST_DRAIN: begin
          if (tx_tick) begin
            if ((tick_q + ONE_TICK) >= TICK_TARGET) begin
              state_d = ST_DONE;
            end else begin
              tick_d = tick_q + ONE_TICK;
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    fin_d  = (state_d == ST_DONE);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      last_q       <= '0;
      idx_q        <= '0;
      lat_q        <= '0;
      tick_q       <= '0;
      mem_addr_q   <= '0;
      mem_ren_q    <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      aborted_q    <= 1'b0;
      start_seen_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      lat_q        <= lat_d;
      tick_q       <= tick_d;
      mem_addr_q   <= mem_addr_d;
      mem_ren_q    <= mem_ren_d;
      busy_q       <= busy_d;
      fin_q        <= fin_d;
      aborted_q    <= aborted_d;
      start_seen_q <= start_seen_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_ren  = mem_ren_q;
  assign busy     = busy_q;
  assign fin      = fin_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_frame_retriever.sv
// Testbench for frame_retriever: instance A (BPW=1, RD_LAT=1) and
// instance B (BPW=4, RD_LAT=2). Expected addresses and bytes are queued by
// the stimulus; negedge monitors pop and compare whenever the DUT reads
// memory or hands a byte to the transmitter.
module tb_frame_retriever;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic        rst_n, tx_tick;
  // instance A
  logic        start_n_a, abort_a, tx_ready_a;
  logic [15:0] base_a, last_a, mem_addr_a;
  logic        mem_ren_a, tx_valid_a, busy_a, fin_a, aborted_a;
  logic [7:0]  mem_rdata_a, tx_data_a;
  // instance B
  logic        start_n_b, abort_b, tx_ready_b;
  logic [15:0] base_b, last_b, mem_addr_b;
  logic        mem_ren_b, tx_valid_b, busy_b, fin_b, aborted_b;
  logic [31:0] mem_rdata_b, p1_b;
  logic [7:0]  tx_data_b;

  logic [15:0] ea_a[$], ea_b[$];
  logic [7:0]  eb_a[$], eb_b[$];
  int fin_a_cnt = 0, ab_a_cnt = 0, fin_b_cnt = 0, ab_b_cnt = 0;

  frame_retriever #(.ADDR_W(16), .BPW(1), .RD_LAT(1), .DRAIN_TICKS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_n(start_n_a), .abort(abort_a),
    .base_addr(base_a), .last_idx(last_a), .mem_addr(mem_addr_a),
    .mem_ren(mem_ren_a), .mem_rdata(mem_rdata_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_tick(tx_tick),
    .busy(busy_a), .fin(fin_a), .aborted(aborted_a));

  frame_retriever #(.ADDR_W(16), .BPW(4), .RD_LAT(2), .DRAIN_TICKS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_n(start_n_b), .abort(abort_b),
    .base_addr(base_b), .last_idx(last_b), .mem_addr(mem_addr_b),
    .mem_ren(mem_ren_b), .mem_rdata(mem_rdata_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_tick(tx_tick),
    .busy(busy_b), .fin(fin_b), .aborted(aborted_b));

  function automatic logic [7:0] fa(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] fb(input logic [15:0] a);
    return a[0] ? 32'h44332211 : 32'hDDCCBBAA;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory models: data is valid only RD_LAT cycles after mem_ren.
  initial forever begin
    @(posedge clk);
    cyc++;
    mem_rdata_a <= mem_ren_a ? fa(mem_addr_a) : 8'hEE;
    p1_b        <= mem_ren_b ? fb(mem_addr_b) : 32'hEEEEEEEE;
    mem_rdata_b <= p1_b;
  end

  // Transmitter tick every 10 cycles.
  initial begin
    tx_tick = 1'b0;
    forever begin
      repeat (9) step();
      tx_tick = 1'b1;
      step();
      tx_tick = 1'b0;
    end
  end

  // Instance B transmitter: ready for one cycle out of six.
  initial begin
    tx_ready_b = 1'b0;
    forever begin
      repeat (5) step();
      tx_ready_b = 1'b1;
      step();
      tx_ready_b = 1'b0;
    end
  end

  // Monitor A
  initial begin
    bit drain_armed;
    bit prev_last;
    int ticks;
    int last_tick_cyc;
    drain_armed = 0; prev_last = 0; ticks = 0; last_tick_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        drain_armed = 0; prev_last = 0; ticks = 0;
      end else begin
        if (prev_last) check("valid_drop_a", tx_valid_a, 0);
        prev_last = 0;
        if (mem_ren_a) begin
          check("read_pending_a", ea_a.size() != 0, 1);
          if (ea_a.size() != 0) check("mem_addr_a", mem_addr_a, ea_a.pop_front());
        end
        if (tx_valid_a && tx_ready_a) begin
          check("byte_pending_a", eb_a.size() != 0, 1);
          if (eb_a.size() != 0) begin
            check("tx_data_a", tx_data_a, eb_a.pop_front());
            if (eb_a.size() == 0) begin
              drain_armed = 1; ticks = 0;
            end
          end
          prev_last = 1;
        end
        if (drain_armed && tx_tick) begin
          ticks++; last_tick_cyc = cyc;
        end
        if (fin_a) begin
          fin_a_cnt++;
          check("fin_ticks_a", ticks, 2);
          check("fin_delay_a", cyc - last_tick_cyc, 1);
          drain_armed = 0;
        end
        if (aborted_a) ab_a_cnt++;
      end
    end
  end

  // Monitor B
  initial begin
    int lane;
    bit prev_last, pv, pr;
    logic [7:0] pd;
    lane = 0; prev_last = 0; pv = 0; pr = 0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lane = 0; prev_last = 0; pv = 0; pr = 0;
      end else begin
        if (prev_last) check("valid_drop_b", tx_valid_b, 0);
        prev_last = 0;
        if (pv && !pr && tx_valid_b) check("stall_hold_b", tx_data_b, pd);
        if (mem_ren_b) begin
          check("read_pending_b", ea_b.size() != 0, 1);
          if (ea_b.size() != 0) check("mem_addr_b", mem_addr_b, ea_b.pop_front());
        end
        if (tx_valid_b && tx_ready_b) begin
          check("byte_pending_b", eb_b.size() != 0, 1);
          if (eb_b.size() != 0) check("tx_data_b", tx_data_b, eb_b.pop_front());
          if (lane == 3) begin
            lane = 0; prev_last = 1;
          end else begin
            lane++;
          end
        end
        pv = tx_valid_b; pr = tx_ready_b; pd = tx_data_b;
        if (fin_b) fin_b_cnt++;
        if (aborted_b) ab_b_cnt++;
      end
    end
  end

  task automatic check_zero_a(input string tag);
    check({tag, "_mem_addr"}, mem_addr_a, 0);
    check({tag, "_mem_ren"}, mem_ren_a, 0);
    check({tag, "_tx_data"}, tx_data_a, 0);
    check({tag, "_tx_valid"}, tx_valid_a, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_fin"}, fin_a, 0);
    check({tag, "_aborted"}, aborted_a, 0);
  endtask

  task automatic start_a(input logic [15:0] b, input logic [15:0] l);
    base_a = b; last_a = l;
    start_n_a = 1'b1;
    step();
    start_n_a = 1'b0;
    step();
    check("start_busy_a", busy_a, 1);
    check("start_ren_a", mem_ren_a, 1);
  endtask

  task automatic wait_fin_a(input string nm, input int budget);
    int n;
    int f0;
    n = 0; f0 = fin_a_cnt;
    while (fin_a_cnt == f0 && n < budget) begin
      step(); n++;
    end
    check(nm, fin_a_cnt != f0, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start_n_a = 1'b0; start_n_b = 1'b1;
    abort_a = 1'b0; abort_b = 1'b0; tx_ready_a = 1'b1;
    base_a = 16'h0000; last_a = 16'h0000; base_b = 16'h0000; last_b = 16'h0000;

    // Reset state, then release with start_n already low: no frame.
    repeat (3) step();
    check_zero_a("reset");
    check("reset_busy_b", busy_b, 0);
    check("reset_valid_b", tx_valid_b, 0);
    rst_n = 1'b1;
    repeat (6) step();
    check("no_start_at_release", busy_a, 0);

    // Basic frame; start_n then stays low through completion.
    ea_a.push_back(16'h0010); ea_a.push_back(16'h0011);
    ea_a.push_back(16'h0012); ea_a.push_back(16'h0013);
    eb_a.push_back(8'h4A); eb_a.push_back(8'h4B);
    eb_a.push_back(8'h48); eb_a.push_back(8'h49);
    start_a(16'h0010, 16'd3);
    wait_fin_a("basic_fin_seen", 300);
    repeat (40) step();
    check("basic_fin_count", fin_a_cnt, 1);
    check("basic_idle", busy_a, 0);
    check("basic_bytes_left", eb_a.size(), 0);

    // Address wrap.
    ea_a.push_back(16'hFFFE); ea_a.push_back(16'hFFFF);
    ea_a.push_back(16'h0000); ea_a.push_back(16'h0001);
    eb_a.push_back(8'h5B); eb_a.push_back(8'h5A);
    eb_a.push_back(8'h5A); eb_a.push_back(8'h5B);
    start_a(16'hFFFE, 16'd3);
    wait_fin_a("wrap_fin_seen", 300);
    check("wrap_fin_count", fin_a_cnt, 2);
    check("wrap_reads_left", ea_a.size(), 0);

    // Abort in SEND together with a start edge.
    for (int i = 0; i < 6; i++) begin
      ea_a.push_back(16'h0020 + 16'(i));
      eb_a.push_back(fa(16'h0020 + 16'(i)));
    end
    start_a(16'h0020, 16'd5);
    start_n_a = 1'b1;
    n = 0;
    while (!tx_valid_a && n < 50) begin
      step(); n++;
    end
    check("abort_reached_send", tx_valid_a, 1);
    abort_a = 1'b1; start_n_a = 1'b0;
    step();
    abort_a = 1'b0;
    check("abort_pulse", aborted_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_valid", tx_valid_a, 0);
    check("abort_ren", mem_ren_a, 0);
    check("abort_no_fin", fin_a, 0);
    step();
    check("abort_pulse_end", aborted_a, 0);
    repeat (20) step();
    check("abort_start_ignored", busy_a, 0);
    check("abort_count", ab_a_cnt, 1);
    check("abort_fin_count", fin_a_cnt, 2);
    ea_a.delete(); eb_a.delete();

    // Reset while draining.
    ea_a.push_back(16'h0040); ea_a.push_back(16'h0041);
    eb_a.push_back(8'h1A); eb_a.push_back(8'h1B);
    start_a(16'h0040, 16'd1);
    n = 0;
    while (eb_a.size() != 0 && n < 50) begin
      step(); n++;
    end
    step();
    check("drain_busy", busy_a, 1);
    rst_n = 1'b0;
    step();
    check_zero_a("midreset");
    rst_n = 1'b1;
    repeat (30) step();
    check("midreset_fin_count", fin_a_cnt, 2);
    check("midreset_abort_count", ab_a_cnt, 1);
    check("midreset_idle", busy_a, 0);

    // Instance B: lane order under backpressure.
    ea_b.push_back(16'h0000); ea_b.push_back(16'h0001);
    eb_b.push_back(8'hAA); eb_b.push_back(8'hBB);
    eb_b.push_back(8'hCC); eb_b.push_back(8'hDD);
    eb_b.push_back(8'h11); eb_b.push_back(8'h22);
    eb_b.push_back(8'h33); eb_b.push_back(8'h44);
    base_b = 16'h0000; last_b = 16'd1;
    start_n_b = 1'b0;
    step();
    check("b_start_busy", busy_b, 1);
    n = 0;
    while (fin_b_cnt == 0 && n < 600) begin
      step(); n++;
    end
    check("b_fin_seen", fin_b_cnt, 1);
    check("b_bytes_left", eb_b.size(), 0);
    check("b_reads_left", ea_b.size(), 0);
    check("b_no_abort", ab_b_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
